sampling_rate_ctrl: RTL and testbench

Parametrised sample-rate controller for the function-generator datapath. After a power-up settling interval it emits a one-cycle `Ready` pulse. It then produces a periodic `Enable` sample strobe whose period comes from a per-mode divider table. Mode requests (step up, step down, direct load) are queued and applied only on a strobe boundary, so a sample period is never truncated. It sits between the front-panel button logic and the sample/DDS pipeline, and generalises the fixed 5-mode sampler to N modes, bidirectional stepping and direct mode selection.

---
 rtl/sampling_pkg.sv | 31 +++
 rtl/btn_debounce.sv | 44 ++++
 rtl/sampling_rate_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_sampling_rate_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sampling_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sampling_pkg
// Description : Shared defaults and types for the sample-rate controller.
//               Holds the default rate-mode count, divider width, startup
//               interval, debounce window and divider table, plus the
//               request-decoder enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
package sampling_pkg;

   localparam int c_def_num_modes      = 5;
   localparam int c_def_cnt_w          = 15;
   localparam int c_def_startup_cycles = 78;
   localparam int c_def_deb_cycles     = 16;

   // Mode m's divider sits at [m*CNT_W +: CNT_W]; mode 0 is the fastest
   // (divider 0 -> strobe every cycle), mode 4 the slowest.
   localparam logic [c_def_num_modes*c_def_cnt_w-1:0] c_def_div_table =
      {15'd10000, 15'd1000, 15'd100, 15'd10, 15'd0};

   // Decoded mode request presented to the capture logic in one cycle.
   typedef enum logic [1:0] {
      REQ_NONE = 2'd0,
      REQ_UP   = 2'd1,
      REQ_DOWN = 2'd2,
      REQ_LOAD = 2'd3
   } mode_req_e;

endpackage : sampling_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Level debounce filter. The output follows the input only
//               after the input has differed from the output for DEB_CYCLES
//               consecutive cycles; shorter glitches are discarded.
// Ports       : Fg_clk  - clock
//               Reset   - synchronous active-high reset (output cleared)
//               btn_in  - synchronised button level
//               btn_out - filtered button level
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
   parameter int DEB_CYCLES = 16
) (
   input  logic Fg_clk,
   input  logic Reset,
   input  logic btn_in,
   output logic btn_out
);

   localparam int                 c_cnt_w = $clog2(DEB_CYCLES + 1);
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DEB_CYCLES - 1);

   logic [c_cnt_w-1:0] r_cnt;

   // r_cnt counts consecutive cycles in which the input disagrees with the
   // filtered level; any agreeing cycle restarts the window.
   always_ff @(posedge Fg_clk) begin
      if (Reset) begin
         r_cnt   <= '0;
         btn_out <= 1'b0;
      end else if (btn_in == btn_out) begin
         r_cnt <= '0;
      end else if (r_cnt == c_last) begin
         btn_out <= btn_in;
         r_cnt   <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule : btn_debounce
`default_nettype wire

// File: rtl/sampling_rate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sampling_rate_ctrl
// Description : Sample-rate controller for the function-generator datapath.
//               Emits a one-cycle Ready pulse after a startup interval, then a
//               periodic Enable strobe whose period is DIV_TABLE[Mode]+1.
//               Up/down/load mode requests accumulate in a pending target and
//               are applied only on a strobe boundary.
// Config      : SAMPLING_RATE_CTRL_DEBOUNCE_EN - when defined, IntBtn/DecBtn
//               pass through btn_debounce (DEB_CYCLES window) after the
//               synchroniser; otherwise the synchronised level is used raw.
// Ports       : Fg_clk   - clock
//               Reset    - synchronous active-high reset
//               IntBtn   - step mode up (rising edge)
//               DecBtn   - step mode down (rising edge)
//               ModeLoad - one-cycle direct-load request
//               ModeIn   - target mode for ModeLoad
//               Ready    - one-cycle pulse when startup completes
//               Running  - high from Ready onward
//               Enable   - sample strobe
//               Mode     - current mode
//               ModeChg  - one-cycle pulse when a new mode takes effect
// Revision    : 1.0 - initial release
// ============================================================================
module sampling_rate_ctrl
   import sampling_pkg::*;
#(
   parameter int                           NUM_MODES      = c_def_num_modes,
   parameter int                           CNT_W          = c_def_cnt_w,
   parameter logic [NUM_MODES*CNT_W-1:0]   DIV_TABLE      = c_def_div_table,
   parameter int                           STARTUP_CYCLES = c_def_startup_cycles,
   parameter int                           DEB_CYCLES     = c_def_deb_cycles,
   localparam int                          MODE_W         = $clog2(NUM_MODES)
) (
   input  logic              Fg_clk,
   input  logic              Reset,
   input  logic              IntBtn,
   input  logic              DecBtn,
   input  logic              ModeLoad,
   input  logic [MODE_W-1:0] ModeIn,
   output logic              Ready,
   output logic              Running,
   output logic              Enable,
   output logic [MODE_W-1:0] Mode,
   output logic              ModeChg
);

   localparam int                 c_st_w     = $clog2(STARTUP_CYCLES + 1);
   localparam logic [c_st_w-1:0]  c_st_last  = c_st_w'(STARTUP_CYCLES - 1);
   localparam logic [c_st_w-1:0]  c_st_end   = c_st_w'(STARTUP_CYCLES);
   localparam logic [MODE_W-1:0]  c_mode_max = MODE_W'(NUM_MODES - 1);

   // ------------------------------------------------------------------------
   // Input conditioning. Buttons go through a 2-flop synchroniser; ModeLoad
   // and ModeIn are delayed by the same two stages so that a load and a
   // button edge presented together reach the decoder together.
   // ------------------------------------------------------------------------
   logic [1:0]        r_int_sync;
   logic [1:0]        r_dec_sync;
   logic [1:0]        r_load_dly;
   logic [MODE_W-1:0] r_modein_d1;
   logic [MODE_W-1:0] r_modein_d2;
   logic              r_int_prev;
   logic              r_dec_prev;
   logic              w_int_filt;
   logic              w_dec_filt;

   always_ff @(posedge Fg_clk) begin
      if (Reset) begin
         r_int_sync  <= '0;
         r_dec_sync  <= '0;
         r_load_dly  <= '0;
         r_modein_d1 <= '0;
         r_modein_d2 <= '0;
         r_int_prev  <= 1'b0;
         r_dec_prev  <= 1'b0;
      end else begin
         r_int_sync  <= {r_int_sync[0], IntBtn};
         r_dec_sync  <= {r_dec_sync[0], DecBtn};
         r_load_dly  <= {r_load_dly[0], ModeLoad};
         r_modein_d1 <= ModeIn;
         r_modein_d2 <= r_modein_d1;
         r_int_prev  <= w_int_filt;
         r_dec_prev  <= w_dec_filt;
      end
   end

`ifdef SAMPLING_RATE_CTRL_DEBOUNCE_EN
   btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_int_deb (
      .Fg_clk  (Fg_clk),
      .Reset   (Reset),
      .btn_in  (r_int_sync[1]),
      .btn_out (w_int_filt)
   );

   btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_dec_deb (
      .Fg_clk  (Fg_clk),
      .Reset   (Reset),
      .btn_in  (r_dec_sync[1]),
      .btn_out (w_dec_filt)
   );
`else
   // No filter: the synchronised level feeds the edge detector directly and
   // the debounce window has no effect in this build.
   if (DEB_CYCLES >= 0) begin : g_raw_btn
      assign w_int_filt = r_int_sync[1];
      assign w_dec_filt = r_dec_sync[1];
   end else begin : g_raw_btn_any
      assign w_int_filt = r_int_sync[1];
      assign w_dec_filt = r_dec_sync[1];
   end
`endif

   logic w_up_edge;
   logic w_dn_edge;

   assign w_up_edge = w_int_filt & ~r_int_prev;
   assign w_dn_edge = w_dec_filt & ~r_dec_prev;

   // ------------------------------------------------------------------------
   // Request decode and next-target computation
   // ------------------------------------------------------------------------
   logic              r_pend;
   logic [MODE_W-1:0] r_tgt;
   logic              w_load_ok;
   mode_req_e         w_req;
   logic [MODE_W-1:0] w_base;
   logic [MODE_W-1:0] w_next;

   assign w_load_ok = r_load_dly[1] && (32'(r_modein_d2) < NUM_MODES);

   always_comb begin
      w_req = REQ_NONE;
      if (w_load_ok) begin
         w_req = REQ_LOAD;
      end else if (w_up_edge && !w_dn_edge) begin
         w_req = REQ_UP;
      end else if (w_dn_edge && !w_up_edge) begin
         w_req = REQ_DOWN;
      end
   end

   // Requests stack on the pending target so several presses between
   // strobes accumulate.
   always_comb begin
      w_base = r_pend ? r_tgt : Mode;
      w_next = w_base;
      case (w_req)
         REQ_UP:   w_next = (w_base == c_mode_max) ? '0 : w_base + MODE_W'(1);
         REQ_DOWN: w_next = (w_base == '0) ? c_mode_max : w_base - MODE_W'(1);
         REQ_LOAD: w_next = r_modein_d2;
         default:  w_next = w_base;
      endcase
   end

   // ------------------------------------------------------------------------
   // Startup sequencer: saturating counter, Ready fires once on arrival.
   // ------------------------------------------------------------------------
   logic [c_st_w-1:0] r_st_cnt;

   always_ff @(posedge Fg_clk) begin
      if (Reset) begin
         r_st_cnt <= '0;
         Ready    <= 1'b0;
         Running  <= 1'b0;
      end else begin
         Ready <= 1'b0;
         if (r_st_cnt != c_st_end) begin
            r_st_cnt <= r_st_cnt + 1'b1;
            if (r_st_cnt == c_st_last) begin
               Ready   <= 1'b1;
               Running <= 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Rate divider and mode apply
   // ------------------------------------------------------------------------
   logic [CNT_W-1:0] w_div_tab [NUM_MODES];
   logic [CNT_W-1:0] w_div;
   logic [CNT_W-1:0] r_div_cnt;
   logic             w_apply;

   for (genvar g = 0; g < NUM_MODES; g++) begin : g_div_tab
      assign w_div_tab[g] = DIV_TABLE[g*CNT_W +: CNT_W];
   end

   assign w_div   = w_div_tab[Mode];
   assign w_apply = Running & Enable & r_pend;

   always_ff @(posedge Fg_clk) begin
      if (Reset) begin
         r_div_cnt <= '0;
         Enable    <= 1'b0;
         Mode      <= '0;
         ModeChg   <= 1'b0;
         r_pend    <= 1'b0;
         r_tgt     <= '0;
      end else begin
         ModeChg <= w_apply;

         // The apply edge swallows the strobe and restarts the count, so the
         // new period is measured in full from this edge.
         if (!Running) begin
            r_div_cnt <= '0;
            Enable    <= 1'b0;
         end else if (w_apply) begin
            Mode      <= r_tgt;
            r_div_cnt <= '0;
            Enable    <= 1'b0;
         end else if (r_div_cnt == w_div) begin
            r_div_cnt <= '0;
            Enable    <= 1'b1;
         end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
            Enable    <= 1'b0;
         end

         // A request coinciding with an apply uses r_tgt (the mode being
         // applied) as its base and stays pending for the next strobe.
         if (w_req != REQ_NONE) begin
            r_tgt  <= w_next;
            r_pend <= 1'b1;
         end else if (w_apply) begin
            r_pend <= 1'b0;
         end
      end
   end

endmodule : sampling_rate_ctrl
`default_nettype wire

// File: tb/tb_sampling_rate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sampling_rate_ctrl
// Description : Self-checking bench for sampling_rate_ctrl with default
//               parameters. A transaction-level reference tracks the
//               committed mode and the pending target; every sampled cycle
//               checks Ready/Running, the strobe spacing and Mode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sampling_rate_ctrl;

   localparam int c_nm      = 5;
   localparam int c_startup = 78;
`ifdef SAMPLING_RATE_CTRL_DEBOUNCE_EN
   localparam int c_hold    = 20;
`else
   localparam int c_hold    = 2;
`endif

   logic       Fg_clk   = 1'b0;
   logic       Reset    = 1'b1;
   logic       IntBtn   = 1'b0;
   logic       DecBtn   = 1'b0;
   logic       ModeLoad = 1'b0;
   logic [2:0] ModeIn   = 3'd0;
   logic       Ready;
   logic       Running;
   logic       Enable;
   logic [2:0] Mode;
   logic       ModeChg;

   sampling_rate_ctrl dut (
      .Fg_clk   (Fg_clk),
      .Reset    (Reset),
      .IntBtn   (IntBtn),
      .DecBtn   (DecBtn),
      .ModeLoad (ModeLoad),
      .ModeIn   (ModeIn),
      .Ready    (Ready),
      .Running  (Running),
      .Enable   (Enable),
      .Mode     (Mode),
      .ModeChg  (ModeChg)
   );

   always #5 Fg_clk = ~Fg_clk;

   int n_checks = 0;
   int n_fail   = 0;
   int div_tab [c_nm] = '{0, 10, 100, 1000, 10000};

   // Reference state
   int m_mode    = 0;
   int m_tgt     = 0;
   bit m_pend    = 0;
   int cyc       = 0;
   int gap       = 0;
   int chg_cnt   = 0;
   int ready_cnt = 0;
   bit have_ref  = 0;
   bit saw_en    = 0;
   bit in_reset  = 1;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle, sampled on the falling edge, with all per-cycle checks.
   task automatic tick();
      @(negedge Fg_clk);
      saw_en = 0;
      if (in_reset) return;
      cyc++;
      check("ready", Ready, cyc == c_startup);
      check("running", Running, cyc >= c_startup);
      if (!Running) check("en_idle", Enable, 0);
      if (have_ref) gap++;
      if (Ready) begin
         ready_cnt++;
         have_ref = 1;
         gap      = 0;
      end
      if (ModeChg) begin
         chg_cnt++;
         check("chg_pending", m_pend, 1);
         check("chg_mode", Mode, m_tgt);
         check("chg_en_low", Enable, 0);
         m_mode = m_tgt;
         m_pend = 0;
         gap    = 0;
      end else if (Enable) begin
         saw_en = 1;
         if (have_ref) check("en_gap", gap, div_tab[m_mode] + 1);
         gap = 0;
      end else if (have_ref && gap > div_tab[m_mode]) begin
         check("en_late", gap, div_tab[m_mode] + 1);
         gap = 0;
      end
      check("mode", Mode, m_mode);
   endtask

   task automatic model_req(input bit up, input bit dn, input bit ld, input int val);
      int base;
      base = m_pend ? m_tgt : m_mode;
      if (ld && val < c_nm) begin
         m_tgt  = val;
         m_pend = 1;
      end else if (up && !dn) begin
         m_tgt  = (base + 1) % c_nm;
         m_pend = 1;
      end else if (dn && !up) begin
         m_tgt  = (base + c_nm - 1) % c_nm;
         m_pend = 1;
      end
   endtask

   task automatic press(input bit up, input bit dn, input bit ld, input int val);
      model_req(up, dn, ld, val);
      IntBtn   = up;
      DecBtn   = dn;
      ModeLoad = ld;
      ModeIn   = 3'(val);
      tick();
      ModeLoad = 1'b0;
      repeat (c_hold - 1) tick();
      IntBtn = 1'b0;
      DecBtn = 1'b0;
      repeat (c_hold + 1) tick();
   endtask

   task automatic wait_chg(input int c0, input int budget, input string tag);
      int n = 0;
      while (chg_cnt == c0 && n < budget) begin
         tick();
         n++;
      end
      check(tag, chg_cnt - c0, 1);
   endtask

   task automatic wait_en(input int budget);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!saw_en && n < budget);
      check("wait_en", saw_en, 1);
   endtask

   task automatic do_reset(input int n);
      Reset    = 1'b1;
      IntBtn   = 1'b0;
      DecBtn   = 1'b0;
      ModeLoad = 1'b0;
      in_reset = 1;
      repeat (n) @(negedge Fg_clk);
      check("rst_ready", Ready, 0);
      check("rst_running", Running, 0);
      check("rst_enable", Enable, 0);
      check("rst_mode", Mode, 0);
      check("rst_modechg", ModeChg, 0);
      m_mode   = 0;
      m_tgt    = 0;
      m_pend   = 0;
      have_ref = 0;
      gap      = 0;
      cyc      = 0;
      Reset    = 1'b0;
      in_reset = 0;
   endtask

   int c0;
   int k;
   int val;
   bit up, dn, ld;

   initial begin
      do_reset(4);

      // Startup, then continuous strobe in mode 0
      repeat (c_startup + 6) tick();
      check("ready_once", ready_cnt, 1);

      // Single step up: mode 1, period 11
      c0 = chg_cnt;
      press(1, 0, 0, 0);
      wait_chg(c0, 200, "up_apply");
      check("up_mode", Mode, 1);
      repeat (30) tick();

      // Mode 3, then two up presses inside one period: 3 -> 4 -> 0
      c0 = chg_cnt;
      press(0, 0, 1, 3);
      wait_chg(c0, 200, "load3");
      wait_en(1100);
      c0 = chg_cnt;
      press(1, 0, 0, 0);
      press(1, 0, 0, 0);
      wait_chg(c0, 1100, "up_up_wrap");
      check("wrap_mode", Mode, 0);
      repeat (20) tick();
      check("single_chg", chg_cnt - c0, 1);

      // Down from 0 wraps to 4; full 10001-cycle period checked by monitor
      c0 = chg_cnt;
      press(0, 1, 0, 0);
      wait_chg(c0, 200, "down_wrap");
      check("down_mode", Mode, 4);
      wait_en(10100);

      // Up and down together cancel
      c0 = chg_cnt;
      press(1, 1, 0, 0);
      repeat (100) tick();
      check("cancel", chg_cnt - c0, 0);

      // Direct load wins over a simultaneous button edge
      c0 = chg_cnt;
`ifdef SAMPLING_RATE_CTRL_DEBOUNCE_EN
      press(0, 0, 1, 2);
`else
      press(1, 0, 1, 2);
`endif
      wait_chg(c0, 10100, "load_over_btn");
      check("load_mode", Mode, 2);

      // Out-of-range load is ignored
      c0 = chg_cnt;
      press(0, 0, 1, 6);
      repeat (250) tick();
      check("bad_load", chg_cnt - c0, 0);

`ifdef SAMPLING_RATE_CTRL_DEBOUNCE_EN
      // Short glitch never reaches the edge detector
      c0 = chg_cnt;
      IntBtn = 1'b1;
      repeat (5) tick();
      IntBtn = 1'b0;
      repeat (250) tick();
      check("glitch", chg_cnt - c0, 0);
`endif

      // Randomised requests, kept out of the slowest mode to bound run time
      for (int i = 0; i < 40; i++) begin
         k = $urandom_range(0, 5);
         if (k == 5 && m_mode == 3) begin
            wait_en(1100);
            c0 = chg_cnt;
            if ($urandom_range(0, 1) == 1) begin
               press(1, 0, 0, 0);
               press(0, 1, 0, 0);
            end else begin
               press(0, 1, 0, 0);
               press(0, 1, 0, 0);
            end
            wait_chg(c0, 1100, "rnd_group");
         end else if (k == 3 || k == 4) begin
            c0 = chg_cnt;
            if (k == 3) press(1, 1, 0, 0);
            else        press(0, 0, 1, $urandom_range(5, 7));
            repeat (2 * c_hold + 20) tick();
            check("rnd_noop", chg_cnt - c0, 0);
         end else begin
            up  = (k == 0);
            dn  = (k == 1);
            ld  = (k == 2 || k == 5);
            val = $urandom_range(0, 3);
            if ((up && m_mode == 3) || (dn && m_mode == 0)) begin
               up = 0;
               dn = 0;
               ld = 1;
            end
            c0 = chg_cnt;
            press(up, dn, ld, val);
            wait_chg(c0, div_tab[m_mode] + 200, "rnd_apply");
         end
      end

      // Reset with a request pending discards it
      c0 = chg_cnt;
      press(0, 0, 1, 3);
      wait_chg(c0, 1200, "pre_rst_load");
      wait_en(1100);
      press(1, 0, 0, 0);
      repeat (20) tick();
      do_reset(3);
      c0 = chg_cnt;
      repeat (c_startup + 40) tick();
      check("rst_drop", chg_cnt - c0, 0);
      check("ready_twice", ready_cnt, 2);
      check("post_rst_mode", Mode, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_sampling_rate_ctrl
`default_nettype wire
